// File: rtl/result_display_driver.sv
// result_display_driver
//   Registers the add/subtract unit's result (res, carry) and operation on a
//   load strobe and scans it onto a 4-digit, active-low, common-anode
//   7-segment display.
//     digit 0 : result nibble in hex
//     digit 1 : carry/borrow as '1' or '0'
//     digit 2 : operation letter, 'A' (add) or 'S' (subtract)
//     digit 3 : blank
//   Until the first load the display shows dashes on digits 0..2.
//
//   Optional feature macro: BLINK_ON_CARRY_EN
//     When defined, the whole display blinks while a captured value with
//     carry set is shown. The blink half-period is BLINK_DIV digit slots.
//     When undefined, the display is steady.
module result_display_driver #(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned BLINK_DIV   = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] res,
   input  logic       carry,
   input  logic       op,
   output logic       busy,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int unsigned PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IDX_W   = 2;
   localparam int unsigned AN_W    = 4;
   localparam int unsigned SEG_W   = 7;

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);

   // Active-low glyphs, bit order {g,f,e,d,c,b,a}
   localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'b1111111;
   localparam logic [SEG_W-1:0] GLYPH_DASH  = 7'b0111111;
   localparam logic [SEG_W-1:0] GLYPH_ZERO  = 7'b1000000;
   localparam logic [SEG_W-1:0] GLYPH_ONE   = 7'b1111001;
   localparam logic [SEG_W-1:0] GLYPH_A     = 7'b0001000;
   localparam logic [SEG_W-1:0] GLYPH_S     = 7'b0010010;

   localparam logic [AN_W-1:0]  AN_OFF      = 4'b1111;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SHOW = 1'b1
   } state_t;

   state_t             state;
   state_t             state_next;

   logic [PRESC_W-1:0] presc;
   logic               tick_c;
   logic [IDX_W-1:0]   idx;

   logic [3:0]         res_q;
   logic               carry_q;
   logic               op_q;

   logic [SEG_W-1:0]   glyph_c;
   logic [AN_W-1:0]    an_c;

   // Hex nibble to active-low segment pattern
   function automatic logic [SEG_W-1:0] hex_glyph(input logic [3:0] v);
      logic [SEG_W-1:0] g;
      case (v)
         4'h0:    g = 7'b1000000;
         4'h1:    g = 7'b1111001;
         4'h2:    g = 7'b0100100;
         4'h3:    g = 7'b0110000;
         4'h4:    g = 7'b0011001;
         4'h5:    g = 7'b0010010;
         4'h6:    g = 7'b0000010;
         4'h7:    g = 7'b1111000;
         4'h8:    g = 7'b0000000;
         4'h9:    g = 7'b0010000;
         4'hA:    g = 7'b0001000;
         4'hB:    g = 7'b0000011;
         4'hC:    g = 7'b1000110;
         4'hD:    g = 7'b0100001;
         4'hE:    g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      return g;
   endfunction

   // Terminal count of the refresh prescaler marks a digit-slot boundary
   assign tick_c = (presc == PRESC_LAST);

   // Refresh prescaler: 0..REFRESH_DIV-1, wraps on tick
   always_ff @(posedge clk) begin
      if (reset) begin
         presc <= '0;
      end else if (tick_c) begin
         presc <= '0;
      end else begin
         presc <= presc + PRESC_W'(1);
      end
   end

   // Digit index advances once per slot, wrapping 3 -> 0 naturally
   always_ff @(posedge clk) begin
      if (reset) begin
         idx <= '0;
      end else if (tick_c) begin
         idx <= idx + IDX_W'(1);
      end
   end

   // Capture registers; a held load recaptures every cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         res_q   <= '0;
         carry_q <= 1'b0;
         op_q    <= 1'b0;
      end else if (load) begin
         res_q   <= res;
         carry_q <= carry;
         op_q    <= op;
      end
   end

`ifdef BLINK_ON_CARRY_EN
   localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_phase;

   // Slot counter toggles the blink phase every BLINK_DIV ticks
   always_ff @(posedge clk) begin
      if (reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (tick_c) begin
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt   <= blink_cnt + BLINK_W'(1);
         end
      end
   end
`else
   logic unused_blink_div_c;
   assign unused_blink_div_c = ^BLINK_DIV;
`endif

   // FSM state register; busy mirrors the registered state
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next == ST_SHOW);
      end
   end

   // FSM next state: load enters/stays in SHOW, only reset leaves it
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (load) state_next = ST_SHOW;
         ST_SHOW: state_next = ST_SHOW;
         default: state_next = ST_IDLE;
      endcase
   end

   // FSM output: glyph and enable for the digit selected this slot
   always_comb begin
      glyph_c = GLYPH_BLANK;
      an_c    = ~(4'b0001 << idx);
      case (idx)
         2'd0: glyph_c = (state == ST_SHOW) ? hex_glyph(res_q) : GLYPH_DASH;
         2'd1: glyph_c = (state == ST_SHOW) ? (carry_q ? GLYPH_ONE : GLYPH_ZERO)
                                            : GLYPH_DASH;
         2'd2: glyph_c = (state == ST_SHOW) ? (op_q ? GLYPH_S : GLYPH_A)
                                            : GLYPH_DASH;
         default: glyph_c = GLYPH_BLANK;
      endcase
`ifdef BLINK_ON_CARRY_EN
      if ((state == ST_SHOW) && carry_q && blink_phase) begin
         an_c = AN_OFF;
      end
`endif
   end

   // Display registers update only on slot boundaries; dark until first tick
   always_ff @(posedge clk) begin
      if (reset) begin
         an  <= AN_OFF;
         seg <= GLYPH_BLANK;
      end else if (tick_c) begin
         an  <= an_c;
         seg <= glyph_c;
      end
   end

   // Decimal point is never lit
   assign dp = 1'b1;

endmodule

// File: tb/tb_result_display_driver.sv
// Directed bench for result_display_driver with REFRESH_DIV=4, BLINK_DIV=2.
module tb_result_display_driver;

   localparam int unsigned REFRESH_DIV = 4;
   localparam int unsigned BLINK_DIV   = 2;
   localparam int unsigned WAIT_BUDGET = 5 * REFRESH_DIV;

   localparam logic [6:0] G_BLANK = 7'b1111111;
   localparam logic [6:0] G_DASH  = 7'b0111111;
   localparam logic [6:0] G_0     = 7'b1000000;
   localparam logic [6:0] G_1     = 7'b1111001;
   localparam logic [6:0] G_3     = 7'b0110000;
   localparam logic [6:0] G_5     = 7'b0010010;
   localparam logic [6:0] G_A     = 7'b0001000;
   localparam logic [6:0] G_S     = 7'b0010010;
   localparam logic [6:0] G_F     = 7'b0001110;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       load  = 1'b0;
   logic [3:0] res   = 4'h0;
   logic       carry = 1'b0;
   logic       op    = 1'b0;
   logic       busy;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   result_display_driver #(
      .REFRESH_DIV (REFRESH_DIV),
      .BLINK_DIV   (BLINK_DIV)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .res   (res),
      .carry (carry),
      .op    (op),
      .busy  (busy),
      .an    (an),
      .seg   (seg),
      .dp    (dp)
   );

   task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Step negedges until an shows target (bounded), then compare an
   task automatic wait_an(input string tag, input logic [3:0] target);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((an !== target) && (n < WAIT_BUDGET));
      check({tag, " an"}, 7'(an), 7'(target));
   endtask

   initial begin
      logic [3:0] exp_an;

      // 1. reset for three edges, then dark until the first tick
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst an",   7'(an),   7'(4'b1111));
      check("rst seg",  seg,      G_BLANK);
      check("rst dp",   7'(dp),   7'(1'b1));
      check("rst busy", 7'(busy), 7'(1'b0));
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("dark an",  7'(an), 7'(4'b1111));
         check("dark seg", seg,    G_BLANK);
      end
      @(negedge clk);
      check("first tick an", 7'(an), 7'(4'b1110));
      check("idle d0 seg",   seg,    G_DASH);
      wait_an("idle d1", 4'b1101);
      check("idle d1 seg", seg, G_DASH);
      wait_an("idle d2", 4'b1011);
      check("idle d2 seg", seg, G_DASH);
      wait_an("idle d3", 4'b0111);
      check("idle d3 seg", seg, G_BLANK);
      check("idle busy", 7'(busy), 7'(1'b0));

      // 2. load A, carry=1, add
      res = 4'hA; carry = 1'b1; op = 1'b0; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check("load busy", 7'(busy), 7'(1'b1));
      wait_an("s2 d0", 4'b1110);
      check("s2 d0 seg", seg, G_A);
      wait_an("s2 d1", 4'b1101);
      check("s2 d1 seg", seg, G_1);
      wait_an("s2 d2", 4'b1011);
      check("s2 d2 seg", seg, G_A);
      wait_an("s2 d3", 4'b0111);
      check("s2 d3 seg", seg, G_BLANK);

      // 3. load 5, carry=0, subtract
      res = 4'h5; carry = 1'b0; op = 1'b1; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_an("s3 d0", 4'b1110);
      check("s3 d0 seg", seg, G_5);
      wait_an("s3 d1", 4'b1101);
      check("s3 d1 seg", seg, G_0);
      wait_an("s3 d2", 4'b1011);
      check("s3 d2 seg", seg, G_S);
      wait_an("s3 d3", 4'b0111);
      check("s3 d3 seg", seg, G_BLANK);

      // load on the same edge as the digit-0 tick: old value shown this slot
      repeat (3) @(negedge clk);
      res = 4'hF; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check("coinc an",  7'(an), 7'(4'b1110));
      check("coinc seg", seg,    G_5);
      wait_an("coinc d1", 4'b1101);
      wait_an("coinc d2", 4'b1011);
      wait_an("coinc d3", 4'b0111);
      wait_an("coinc d0", 4'b1110);
      check("coinc new seg", seg, G_F);

      // held load: last captured value wins
      res = 4'h1; load = 1'b1;
      @(negedge clk);
      res = 4'h2;
      @(negedge clk);
      res = 4'h3;
      @(negedge clk);
      load = 1'b0; res = 4'h0;
      wait_an("hold d1", 4'b1101);
      wait_an("hold d2", 4'b1011);
      wait_an("hold d3", 4'b0111);
      wait_an("hold d0", 4'b1110);
      check("hold seg",  seg,      G_3);
      check("hold busy", 7'(busy), 7'(1'b1));

      // 4. 16 ticks, four clocks each, aligned to the digit-0 tick
      for (int i = 0; i < 64; i++) begin
         exp_an = ~(4'b0001 << ((i / 4) % 4));
         check("scan an", 7'(an), 7'(exp_an));
         @(negedge clk);
      end

      // 5. reset (with a coincident load) while digit 2 is shown
      wait_an("pre-rst d2", 4'b1011);
      reset = 1'b1; load = 1'b1; res = 4'h7; carry = 1'b1;
      @(negedge clk);
      reset = 1'b0; load = 1'b0;
      check("mid rst an",   7'(an),   7'(4'b1111));
      check("mid rst seg",  seg,      G_BLANK);
      check("mid rst busy", 7'(busy), 7'(1'b0));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rst dark an", 7'(an), 7'(4'b1111));
      end
      @(negedge clk);
      check("restart an",   7'(an),   7'(4'b1110));
      check("restart seg",  seg,      G_DASH);
      check("restart busy", 7'(busy), 7'(1'b0));
      wait_an("restart d1", 4'b1101);
      check("restart d1 seg", seg, G_DASH);
      check("restart dp", 7'(dp), 7'(1'b1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
